// File: rtl/multiplier32.sv
// multiplier32: sequential 32x32 shift-add multiplier that rebuilds a dividend
// A = D*B + R from quotient D, divisor B and remainder R.
// One shift-add step per cycle, fixed 32-cycle latency from start to result.
// Optional build macro MULTIPLIER32_REM_CHECK_EN adds a remainder range check
// (R >= B flags err); without it err reports 64-bit overflow only.
//
// Handshake: start is a level request sampled in IDLE. The result (A plus
// exactly one of ok/err) is held in DONE until start is seen low, so a held
// start never launches a second operation. busy is high only in RUN.
module multiplier32 (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] D,
  input  logic [31:0] B,
  input  logic [31:0] R,
  output logic [31:0] A,
  output logic        ok,
  output logic        err,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [63:0] acc;
  logic [63:0] mcand;
  logic [31:0] mplier;
  logic [5:0]  cnt;
  logic [63:0] acc_step;
  logic        last_step;
  logic        res_err;
`ifdef MULTIPLIER32_REM_CHECK_EN
  logic        rem_bad;
`endif

  // Accumulator value after this cycle's shift-add step.
  always_comb begin
    acc_step  = mplier[0] ? (acc + mcand) : acc;
    last_step = (cnt == 6'd31);
`ifdef MULTIPLIER32_REM_CHECK_EN
    res_err   = (|acc_step[63:32]) | rem_bad;
`else
    res_err   = |acc_step[63:32];
`endif
  end

  // State register, asynchronously forced to IDLE by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_step) state_nxt = DONE;
      DONE:    if (!start) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latch, shift-add datapath and result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc    <= 64'd0;
      mcand  <= 64'd0;
      mplier <= 32'd0;
      cnt    <= 6'd0;
      A      <= 32'd0;
      ok     <= 1'b0;
      err    <= 1'b0;
`ifdef MULTIPLIER32_REM_CHECK_EN
      rem_bad <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc    <= {32'd0, R};
            mcand  <= {32'd0, B};
            mplier <= D;
            cnt    <= 6'd0;
`ifdef MULTIPLIER32_REM_CHECK_EN
            rem_bad <= (R >= B);
`endif
          end
        end
        RUN: begin
          acc    <= acc_step;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 6'd1;
          if (last_step) begin
            A   <= acc_step[31:0];
            err <= res_err;
            ok  <= ~res_err;
          end
        end
        DONE: begin
          // A keeps its value after leaving DONE; only the flags clear.
          if (!start) begin
            ok  <= 1'b0;
            err <= 1'b0;
          end
        end
        default: begin
          ok  <= 1'b0;
          err <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = (state == RUN);
  assign dbg_state = state;

endmodule

// File: tb/tb_multiplier32.sv
// tb_multiplier32: randomized and directed checks of multiplier32 against a
// plain-arithmetic model of D*B + R with overflow / remainder rules.
module tb_multiplier32;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] D;
  logic [31:0] B;
  logic [31:0] R;
  logic [31:0] A;
  logic        ok;
  logic        err;
  logic        busy;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  // {err, ok, A} expected for each launched operation
  logic [33:0] exp_q[$];

  multiplier32 dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .D         (D),
    .B         (B),
    .R         (R),
    .A         (A),
    .ok        (ok),
    .err       (err),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model: full-width arithmetic, then the result rules
  function automatic logic [33:0] model(input logic [31:0] d, input logic [31:0] b,
                                        input logic [31:0] r);
    logic [63:0] full;
    logic        bad;
    full = 64'(d) * 64'(b) + 64'(r);
    bad  = (full > 64'h0000_0000_FFFF_FFFF);
`ifdef MULTIPLIER32_REM_CHECK_EN
    if (r >= b) bad = 1'b1;
`endif
    return {bad, ~bad, full[31:0]};
  endfunction

  // launch one operation and check latency, busy window and result
  task automatic do_op(input logic [31:0] d, input logic [31:0] b, input logic [31:0] r,
                       input bit hold, input string tag);
    int nbusy;
    int early;
    logic [33:0] e;
    logic [31:0] a_prev;
    exp_q.push_back(model(d, b, r));
    @(negedge clk);
    D = d; B = b; R = r; start = 1'b1;
    @(posedge clk);                      // launch edge k
    nbusy = 0;
    early = 0;
    for (int n = 0; n < 32; n++) begin   // samples after edges k .. k+31
      @(negedge clk);
      if (busy) nbusy++;
      if (ok || err) early++;
      if (!hold) start = 1'b0;
      D = $urandom; B = $urandom; R = $urandom;
    end
    check({tag, "_busy_cycles"}, 64'(nbusy), 64'd32);
    check({tag, "_early_result"}, 64'(early), 64'd0);
    @(negedge clk);                      // after edge k+32
    e = exp_q.pop_front();
    check({tag, "_A"}, 64'(A), 64'(e[31:0]));
    check({tag, "_ok_err"}, 64'({err, ok}), 64'(e[33:32]));
    check({tag, "_busy_done"}, 64'(busy), 64'd0);
    if (!hold) begin
      a_prev = A;
      @(negedge clk);                    // DONE -> IDLE on start low
      check({tag, "_idle_flags"}, 64'({err, ok, busy}), 64'd0);
      check({tag, "_idle_A_held"}, 64'(A), 64'(a_prev));
    end
  endtask

  initial begin
    logic [31:0] rd, rb, rr;
    logic [31:0] a_done;
    logic [1:0]  f_done;
    int extra_busy;
    int flag_change;

    reset = 1'b0; start = 1'b0; D = '0; B = '0; R = '0;
    #1;
    check("reset_outputs", {A, ok, err, busy, dbg_state}, 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // directed cases
    do_op(32'd3, 32'd4, 32'd2, 1'b0, "d3b4r2");
    do_op(32'h0003_0000, 32'h0004_0000, 32'd0, 1'b0, "ovf_prod");
    do_op(32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, "ovf_rterm");
    do_op(32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, "max_noovf");
    do_op(32'd0, 32'd9, 32'd5, 1'b0, "d_zero");
    do_op(32'd12345, 32'd0, 32'd77, 1'b0, "b_zero");

    // reset 10 cycles into RUN aborts the operation
    @(negedge clk);
    D = 32'd1000; B = 32'd1000; R = 32'd1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrun_reset", {A, ok, err, busy, dbg_state}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    check("aborted_no_result", {A, ok, err, busy}, 64'd0);
    do_op(32'd7, 32'd6, 32'd0, 1'b0, "after_reset");

    // start held high 256 cycles: exactly one operation
    do_op(32'd5, 32'd3, 32'd3, 1'b1, "held");
    a_done = A;
    f_done = {err, ok};
    extra_busy = 0;
    flag_change = 0;
    for (int n = 0; n < 256 - 33; n++) begin
      @(negedge clk);
      if (busy) extra_busy++;
      if ({err, ok} !== f_done || A !== a_done) flag_change++;
    end
    check("held_no_retrigger", 64'(extra_busy), 64'd0);
    check("held_result_stable", 64'(flag_change), 64'd0);
    start = 1'b0;
    @(negedge clk);
    check("held_release_flags", 64'({err, ok, busy}), 64'd0);
    do_op(32'd5, 32'd3, 32'd3, 1'b0, "held_second");

    // randomized operands, including narrow ranges to hit ok results
    for (int i = 0; i < 24; i++) begin
      case (i % 3)
        0: begin rd = $urandom; rb = $urandom; rr = $urandom; end
        1: begin rd = $urandom_range(65535, 0); rb = $urandom_range(65535, 0);
                 rr = $urandom_range(70000, 0); end
        default: begin rd = $urandom_range(3, 0); rb = $urandom; rr = $urandom_range(255, 0); end
      endcase
      do_op(rd, rb, rr, 1'b0, "rand");
    end

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // global time bound
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
